// File: rtl/mem_stage_oq.sv
// ---------------------------------------------------------------------------
// mem_stage_oq
// MEM pipeline stage with an in-order outstanding-request queue. Several
// data-SRAM requests may be in flight; in-order data_ok responses are matched
// to the oldest entry still waiting, load data is extracted at the head, and
// results retire to WB in program order. Responses owed to flushed requests
// are swallowed through a drop counter.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      discard every queued entry
//   es_to_ms_valid/ms_allowin  EX -> MEM handshake (ms_allowin = !full)
//   es_req, es_res_from_mem,
//   es_ld_op, es_addr_lo,
//   es_rt, es_gr_we, es_dest,
//   es_alu_result, es_pc       instruction context captured on push
//   data_sram_data_ok/rdata    in-order SRAM responses
//   ws_allowin/ms_to_ws_valid  MEM -> WB handshake
//   ms_gr_we, ms_dest,
//   ms_result, ms_pc           head entry towards WB
//   fwd_dest, fwd_data_valid   forwarding information for the head entry
//   pending_cnt, drop_cnt      occupancy and responses still to discard
//   resp_err                   sticky: response arrived with nothing owed
// ---------------------------------------------------------------------------
module mem_stage_oq #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             es_to_ms_valid,
   output logic             ms_allowin,
   input  logic             es_req,
   input  logic             es_res_from_mem,
   input  logic [2:0]       es_ld_op,
   input  logic [1:0]       es_addr_lo,
   input  logic [31:0]      es_rt,
   input  logic             es_gr_we,
   input  logic [4:0]       es_dest,
   input  logic [31:0]      es_alu_result,
   input  logic [31:0]      es_pc,
   input  logic             data_sram_data_ok,
   input  logic [31:0]      data_sram_rdata,
   input  logic             ws_allowin,
   output logic             ms_to_ws_valid,
   output logic             ms_gr_we,
   output logic [4:0]       ms_dest,
   output logic [31:0]      ms_result,
   output logic [31:0]      ms_pc,
   output logic [4:0]       fwd_dest,
   output logic             fwd_data_valid,
   output logic [CNT_W-1:0] pending_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             resp_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_req;
   logic [DEPTH-1:0] r_done;
   logic [DEPTH-1:0] r_resFromMem;
   logic [DEPTH-1:0] r_grWe;
   logic [2:0]       r_ldOp      [DEPTH];
   logic [1:0]       r_addrLo    [DEPTH];
   logic [31:0]      r_rt        [DEPTH];
   logic [4:0]       r_dest      [DEPTH];
   logic [31:0]      r_aluResult [DEPTH];
   logic [31:0]      r_pc        [DEPTH];
   logic [31:0]      r_rdata     [DEPTH];

   logic [PTR_W-1:0] r_headPtr;
   logic [PTR_W-1:0] r_tailPtr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_dropCnt;
   logic             r_respErr;

   logic             w_push;
   logic             w_pop;
   logic             w_headValid;
   logic             w_matchFound;
   logic [PTR_W-1:0] w_matchIdx;
   logic [PTR_W-1:0] w_scanIdx;
   logic [CNT_W-1:0] w_owedCnt;
   logic             w_dropResp;
   logic             w_entryResp;
   logic             w_strayResp;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_ext;

   assign ms_allowin     = (r_count < CNT_W'(DEPTH));
   assign w_headValid    = r_valid[r_headPtr];
   assign ms_to_ws_valid = w_headValid && r_done[r_headPtr];
   assign w_push         = es_to_ms_valid && ms_allowin;
   assign w_pop          = ms_to_ws_valid && ws_allowin;

   // A response first pays off any debt left by a flush; only then is it
   // offered to the oldest entry still waiting. Anything left is stray.
   assign w_dropResp  = data_sram_data_ok && (r_dropCnt != '0);
   assign w_entryResp = data_sram_data_ok && (r_dropCnt == '0) && w_matchFound;
   assign w_strayResp = data_sram_data_ok && (r_dropCnt == '0) && !w_matchFound;

   // Scan from the head towards the tail so the first hit is the oldest
   // waiting request, and count every request that still owes a response.
   always_comb begin
      w_matchFound = 1'b0;
      w_matchIdx   = '0;
      w_scanIdx    = '0;
      w_owedCnt    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_scanIdx = r_headPtr + PTR_W'(i);
         if (r_valid[w_scanIdx] && r_req[w_scanIdx] && !r_done[w_scanIdx]) begin
            w_owedCnt = w_owedCnt + CNT_W'(1);
            if (!w_matchFound) begin
               w_matchFound = 1'b1;
               w_matchIdx   = w_scanIdx;
            end
         end
      end
   end

   // Load data extraction for the head entry, including the unaligned
   // LWL/LWR merges with the old rt value.
   always_comb begin
      w_byte = 8'h00;
      w_half = r_addrLo[r_headPtr][1] ? r_rdata[r_headPtr][31:16] : r_rdata[r_headPtr][15:0];
      w_ext  = r_rdata[r_headPtr];
      case (r_addrLo[r_headPtr])
         2'd0:    w_byte = r_rdata[r_headPtr][7:0];
         2'd1:    w_byte = r_rdata[r_headPtr][15:8];
         2'd2:    w_byte = r_rdata[r_headPtr][23:16];
         default: w_byte = r_rdata[r_headPtr][31:24];
      endcase
      case (r_ldOp[r_headPtr])
         3'd1: w_ext = {{24{w_byte[7]}}, w_byte};
         3'd2: w_ext = {24'h000000, w_byte};
         3'd3: w_ext = {{16{w_half[15]}}, w_half};
         3'd4: w_ext = {16'h0000, w_half};
         3'd5: begin
            case (r_addrLo[r_headPtr])
               2'd0:    w_ext = {r_rdata[r_headPtr][7:0],  r_rt[r_headPtr][23:0]};
               2'd1:    w_ext = {r_rdata[r_headPtr][15:0], r_rt[r_headPtr][15:0]};
               2'd2:    w_ext = {r_rdata[r_headPtr][23:0], r_rt[r_headPtr][7:0]};
               default: w_ext = r_rdata[r_headPtr];
            endcase
         end
         3'd6: begin
            case (r_addrLo[r_headPtr])
               2'd0:    w_ext = r_rdata[r_headPtr];
               2'd1:    w_ext = {r_rt[r_headPtr][31:24], r_rdata[r_headPtr][31:8]};
               2'd2:    w_ext = {r_rt[r_headPtr][31:16], r_rdata[r_headPtr][31:16]};
               default: w_ext = {r_rt[r_headPtr][31:8],  r_rdata[r_headPtr][31:24]};
            endcase
         end
         default: w_ext = r_rdata[r_headPtr];
      endcase
   end

   // Head outputs are forced to zero while the queue is empty so stale
   // entry contents never leak towards WB or the forwarding network.
   assign ms_result      = w_headValid ? (r_resFromMem[r_headPtr] ? w_ext : r_aluResult[r_headPtr]) : 32'h0;
   assign ms_gr_we       = w_headValid && r_grWe[r_headPtr];
   assign ms_dest        = w_headValid ? r_dest[r_headPtr] : 5'd0;
   assign ms_pc          = w_headValid ? r_pc[r_headPtr] : 32'h0;
   assign fwd_dest       = (w_headValid && r_grWe[r_headPtr]) ? r_dest[r_headPtr] : 5'd0;
   assign fwd_data_valid = ms_to_ws_valid;
   assign pending_cnt    = r_count;
   assign drop_cnt       = r_dropCnt;
   assign resp_err       = r_respErr;

   // Queue state. On flush every request that still owes a response (plus a
   // request pushed this very cycle) becomes debt in the drop counter, less
   // the response that is absorbed in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid      <= '0;
         r_req        <= '0;
         r_done       <= '0;
         r_resFromMem <= '0;
         r_grWe       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ldOp[i]      <= '0;
            r_addrLo[i]    <= '0;
            r_rt[i]        <= '0;
            r_dest[i]      <= '0;
            r_aluResult[i] <= '0;
            r_pc[i]        <= '0;
            r_rdata[i]     <= '0;
         end
         r_headPtr <= '0;
         r_tailPtr <= '0;
         r_count   <= '0;
         r_dropCnt <= '0;
         r_respErr <= 1'b0;
      end else begin
         if (w_strayResp) begin
            r_respErr <= 1'b1;
         end
         if (flush) begin
            r_valid   <= '0;
            r_headPtr <= '0;
            r_tailPtr <= '0;
            r_count   <= '0;
            r_dropCnt <= r_dropCnt + w_owedCnt + CNT_W'(w_push && es_req)
                         - CNT_W'(w_dropResp || w_entryResp);
         end else begin
            if (w_dropResp) begin
               r_dropCnt <= r_dropCnt - CNT_W'(1);
            end
            if (w_entryResp) begin
               r_rdata[w_matchIdx] <= data_sram_rdata;
               r_done[w_matchIdx]  <= 1'b1;
            end
            if (w_pop) begin
               r_valid[r_headPtr] <= 1'b0;
               r_headPtr          <= r_headPtr + PTR_W'(1);
            end
            if (w_push) begin
               r_valid[r_tailPtr]      <= 1'b1;
               r_req[r_tailPtr]        <= es_req;
               r_done[r_tailPtr]       <= !es_req;
               r_resFromMem[r_tailPtr] <= es_res_from_mem;
               r_grWe[r_tailPtr]       <= es_gr_we;
               r_ldOp[r_tailPtr]       <= es_ld_op;
               r_addrLo[r_tailPtr]     <= es_addr_lo;
               r_rt[r_tailPtr]         <= es_rt;
               r_dest[r_tailPtr]       <= es_dest;
               r_aluResult[r_tailPtr]  <= es_alu_result;
               r_pc[r_tailPtr]         <= es_pc;
               r_tailPtr               <= r_tailPtr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         end
      end
   end

endmodule

// File: doc/mem_stage_oq.md
Name: mem_stage_oq

Overview:
- Successor MEM pipeline stage with an in-order outstanding-request queue of DEPTH entries, so several data-SRAM requests can be in flight at once instead of one.
- Each entry holds instruction context plus load-alignment info.
- In-order data_ok responses are matched to the oldest waiting entry, then load data is extracted (LW/LB/LBU/LH/LHU/LWL/LWR).
- Results retire to WB in program order.
- On flush, responses still owed to flushed requests are discarded via a drop counter.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
CNT_W, $clog2(DEPTH+1), width of occupancy and drop counters

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
flush  in  1  exception/ERET flush from WB; discards all entries
es_to_ms_valid  in  1  EX has an instruction for MEM
ms_allowin  out  1  MEM accepts this cycle (= !full)
es_req  in  1  instruction issued a data-SRAM request (load or store) accepted by SRAM in EX
es_res_from_mem  in  1  result comes from load data
es_ld_op  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR
es_addr_lo  in  2  address[1:0]
es_rt  in  32  old rt value for LWL/LWR merge
es_gr_we  in  1  register write enable
es_dest  in  5  destination register
es_alu_result  in  32  ALU result
es_pc  in  32  PC
data_sram_data_ok  in  1  one in-order response this cycle
data_sram_rdata  in  32  response data
ws_allowin  in  1  WB accepts
ms_to_ws_valid  out  1  head entry ready for WB
ms_gr_we  out  1  head gr_we
ms_dest  out  5  head dest
ms_result  out  32  head final result
ms_pc  out  32  head PC
fwd_dest  out  5  head dest if head valid && gr_we, else 0
fwd_data_valid  out  1  = ms_to_ws_valid
pending_cnt  out  CNT_W  valid entries
drop_cnt  out  CNT_W  responses still to be discarded
resp_err  out  1  sticky: data_ok arrived with nothing owed

Behaviour:
- Reset: all entries invalid; ms_to_ws_valid=0, pending_cnt=0, drop_cnt=0, resp_err=0, fwd_dest=0, ms_result=0. ms_allowin=1 in the first cycle after reset.
- Entry fields: valid, req, done, res_from_mem, ld_op, addr_lo, rt, gr_we, dest, alu_result, pc, rdata.
- Circular head/tail pointers plus occupancy count.
- Push: es_to_ms_valid && ms_allowin. Tail entry gets valid=1, done=!es_req.
- Response matching: data_ok with drop_cnt>0 decrements drop_cnt and the data is discarded. Otherwise it goes to the oldest valid entry with req && !done: that entry's rdata is captured and done set (registered).
  - If no such entry exists, the response is ignored and resp_err is set.
- Head ready: ms_to_ws_valid = head.valid && head.done.
  - Latency: a no-request instruction pushed in cycle N is valid at N+1.
  - A load whose data_ok arrives in cycle M is valid at M+1, never earlier.
- Pop: ms_to_ws_valid && ws_allowin. Head invalidated, head pointer advances with wrap-around.
- Full/empty: push and pop in the same cycle is allowed even when full is not required; ms_allowin depends only on count<DEPTH, with no ws_allowin bypass. Empty means ms_to_ws_valid=0.
- Extraction (head, combinational), with b = rdata byte addr_lo and h = rdata half addr_lo[1]:
  - LB: sign-extend b. LBU: zero-extend b. LH: sign-extend h. LHU: zero-extend h.
  - LWL, by addr_lo: 0 -> {rdata[7:0], rt[23:0]}; 1 -> {rdata[15:0], rt[15:0]}; 2 -> {rdata[23:0], rt[7:0]}; 3 -> rdata.
  - LWR, by addr_lo: 0 -> rdata; 1 -> {rt[31:24], rdata[31:8]}; 2 -> {rt[31:16], rdata[31:16]}; 3 -> {rt[31:8], rdata[31:24]}.
  - LW and codes 7: rdata.
  - ms_result = res_from_mem ? extracted : alu_result. Stores: req=1, res_from_mem=0; they wait for their data_ok.
- Flush:
  - Next cycle all entries are invalid, pointers and count are 0.
  - drop_cnt_next = drop_cnt + (number of valid entries with req && !done) + (1 if a push with es_req occurs this cycle) - (1 if this cycle's data_ok is absorbed).
  - Absorbed means it is applied to the drop count or to an entry before counting.
  - A push coincident with flush is discarded. A pop coincident with flush still does not assert anything after flush.
- Reset mid-operation clears everything, including drop_cnt and resp_err.

Test Plan:
- No-request ALU ops x3 back-to-back, ws_allowin=1 -> ms_to_ws_valid each cycle from N+1, results in order, pending_cnt stays <=1.
- Four loads pushed while ws_allowin=0, no data_ok -> ms_allowin=0 after the fourth push, pending_cnt=4. Then data_ok x4 with rdata 0x11..0x44 -> retire in order with those values.
- LB addr_lo=3, rdata=0x80FF_0000 -> ms_result=0xFFFF_FF80. LHU addr_lo=2 -> 0x0000_80FF. LWL addr_lo=1, rt=0xAABB_CCDD -> 0x0000_CCDD. LWR addr_lo=2 -> 0xAABB_80FF.
- Two loads outstanding, flush asserted with no data_ok -> queue empty next cycle, drop_cnt=2. Next two data_ok are discarded, ms_to_ws_valid stays 0, drop_cnt returns to 0. A following load then receives the third response.
- Flush in the same cycle as data_ok for the oldest of three pending loads plus a push with es_req=1 -> drop_cnt=3.
- data_ok with empty queue and drop_cnt=0 -> resp_err=1 and stays 1 until reset. Then reset -> all outputs 0, ms_allowin=1.
